// File: rtl/reflet_bus_pkg.sv
// Shared types and constants for the reflet bus arbiter.
// Holds the arbiter state encoding and the master index values.
package reflet_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/reflet_bus_mux2.sv
// 2:1 bus selector for addr, write_en and data_out.
// Drives all zeros when no master is selected.
module reflet_bus_mux2
  import reflet_bus_pkg::*;
#(
  parameter int wordsize = 8
) (
  input  logic                en,
  input  logic                sel,
  input  logic [wordsize-1:0] a_addr,
  input  logic                a_write_en,
  input  logic [wordsize-1:0] a_data,
  input  logic [wordsize-1:0] b_addr,
  input  logic                b_write_en,
  input  logic [wordsize-1:0] b_data,
  output logic [wordsize-1:0] y_addr,
  output logic                y_write_en,
  output logic [wordsize-1:0] y_data
);

  always_comb begin
    y_addr     = '0;
    y_write_en = 1'b0;
    y_data     = '0;
    if (en) begin
      if (sel == MASTER1) begin
        y_addr     = b_addr;
        y_write_en = b_write_en;
        y_data     = b_data;
      end else begin
        y_addr     = a_addr;
        y_write_en = a_write_en;
        y_data     = a_data;
      end
    end
  end

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Round-robin two-master arbiter with a bounded grant quantum.
// Define REFLET_BUS_ARBITER_LOCK_EN to add m0_lock/m1_lock ports.
module reflet_bus_arbiter
  import reflet_bus_pkg::*;
#(
  parameter int wordsize = 8,
  parameter int quantum  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic                m0_write_en,
  input  logic [wordsize-1:0] m0_data_out,
  output logic                m0_grant,
  output logic [wordsize-1:0] m0_data_in,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic                m1_write_en,
  input  logic [wordsize-1:0] m1_data_out,
  output logic                m1_grant,
  output logic [wordsize-1:0] m1_data_in,
`ifdef REFLET_BUS_ARBITER_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  output logic [wordsize-1:0] bus_addr,
  output logic                bus_write_en,
  output logic [wordsize-1:0] bus_data_out,
  input  logic [wordsize-1:0] bus_data_in
);

  localparam int CW_RAW = $clog2(quantum + 1);
  localparam int CW = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int CNT_MAX_I = (quantum > 0) ? quantum - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX = CW'(CNT_MAX_I);

  arb_state_t    state, state_n;
  logic          last_owner, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          own_lock;
  logic          cnt_top;
  logic          preempt_ok;

`ifdef REFLET_BUS_ARBITER_LOCK_EN
  assign own_lock = (state == ARB_OWN0 && m0_lock) ||
                    (state == ARB_OWN1 && m1_lock);
`else
  assign own_lock = 1'b0;
`endif

  assign cnt_top    = (cnt == CNT_MAX);
  assign preempt_ok = (quantum != 0) && cnt_top && !own_lock;

  always_comb begin
    state_n = state;
    last_n  = last_owner;
    cnt_n   = cnt;
    unique case (state)
      ARB_IDLE: begin
        if (m0_req && m1_req)
          state_n = (last_owner == MASTER0) ? ARB_OWN1 : ARB_OWN0;
        else if (m0_req)
          state_n = ARB_OWN0;
        else if (m1_req)
          state_n = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!m0_req)
          state_n = m1_req ? ARB_OWN1 : ARB_IDLE;
        else if (m1_req && preempt_ok)
          state_n = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!m1_req)
          state_n = m0_req ? ARB_OWN0 : ARB_IDLE;
        else if (m0_req && preempt_ok)
          state_n = ARB_OWN0;
      end
      default: state_n = ARB_IDLE;
    endcase
    // Counter saturates so a late rival request hands over at once.
    if (state_n != state) begin
      cnt_n = '0;
      if (state_n == ARB_OWN0)
        last_n = MASTER0;
      else if (state_n == ARB_OWN1)
        last_n = MASTER1;
    end else if (state != ARB_IDLE && !own_lock && !cnt_top) begin
      cnt_n = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_owner <= MASTER1;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      last_owner <= last_n;
      cnt        <= cnt_n;
    end
  end

  assign m0_grant   = (state == ARB_OWN0);
  assign m1_grant   = (state == ARB_OWN1);
  assign m0_data_in = m0_grant ? bus_data_in : '0;
  assign m1_data_in = m1_grant ? bus_data_in : '0;

  reflet_bus_mux2 #(
    .wordsize(wordsize)
  ) u_mux (
    .en        (state != ARB_IDLE),
    .sel       (state == ARB_OWN1),
    .a_addr    (m0_addr),
    .a_write_en(m0_write_en),
    .a_data    (m0_data_out),
    .b_addr    (m1_addr),
    .b_write_en(m1_write_en),
    .b_data    (m1_data_out),
    .y_addr    (bus_addr),
    .y_write_en(bus_write_en),
    .y_data    (bus_data_out)
  );

endmodule

// File: doc/reflet_bus_arbiter.md
Name: reflet_bus_arbiter

Overview:
Two-master arbiter for the reflet system bus (addr / write_en / data). It shares one peripheral bus (ROM, GPIO, other slaves) between master 0 (the CPU) and master 1 (a second master such as a DMA engine or debug port).
- Grants are round-robin with a bounded time quantum.
- A non-granted master is stalled through its grant line, which drives the CPU's enable input.
- The block sits between the masters and the OR-combined slave data_out network.

Parameters:
- wordsize, 8, width of the address and data buses.
- quantum, 4, maximum consecutive granted cycles before a contended handover. Value 0 disables preemption.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- m0_req  input  1  master 0 requests the bus.
- m0_addr  input  wordsize  master 0 address.
- m0_write_en  input  1  master 0 write strobe.
- m0_data_out  input  wordsize  master 0 write data.
- m0_grant  output  1  master 0 owns the bus; also serves as master 0 enable/stall.
- m0_data_in  output  wordsize  read data to master 0; zero when not granted.
- m1_req, m1_addr, m1_write_en, m1_data_out, m1_grant, m1_data_in  same as the m0 ports, for master 1.
- bus_addr  output  wordsize  address to slaves.
- bus_write_en  output  1  write strobe to slaves.
- bus_data_out  output  wordsize  write data to slaves.
- bus_data_in  input  wordsize  OR of all slave data_out.

Behaviour:
- Reset is asynchronous and active-high; one clock.
- While reset is high:
  - state = IDLE; both grants = 0.
  - bus_addr = 0, bus_write_en = 0, bus_data_out = 0; both mX_data_in = 0.
  - quantum counter = 0; last_owner = 1, so master 0 wins the first tie.
- Reset asserted mid-transfer drops the grants and bus_write_en in the same instant (async). No partial write may continue.
- States:
  - IDLE: the bus is driven to 0.
  - OWN0: the bus is muxed combinationally from the m0 signals.
  - OWN1: the bus is muxed combinationally from the m1 signals.
- Grant latency: one cycle. A req sampled high at edge N gives a grant visible after edge N; the master's bus signals pass through in that cycle.
- IDLE transitions:
  - Only one req high: go to that master's OWN state.
  - Both high: go to the master that is not last_owner.
- OWNx transitions (y is the other master):
  - req_x low: go to OWNy if req_y is high, else IDLE. There is no idle bubble between owners.
  - req_x high, counter = quantum-1, req_y high, quantum != 0: go to OWNy (preemption).
  - Otherwise stay in OWNx.
- Each transition updates last_owner to the newly granted master.
- Quantum counter:
  - Width is $clog2(quantum+1), minimum 1 bit.
  - Increments each cycle in OWNx.
  - Clears on any state change and on entry from IDLE.
  - Stays in OWNx with req_y low: the counter saturates at quantum-1 and does not wrap. The handover happens as soon as req_y rises.
- Read data: mX_data_in = bus_data_in when mX_grant is high, else 0. This is pure combinational and adds no latency beyond the slave's.
- bus_write_en equals the owner's write_en. It is never high in IDLE.
- A master whose grant drops must hold its request signals. Its transaction is re-presented when it is re-granted; the arbiter does not buffer transactions.
- Requests are not latched: req high then low without a grant is ignored.

Optional Feature:
- Macro: REFLET_BUS_ARBITER_LOCK_EN.
- Defined:
  - Adds ports m0_lock and m1_lock (input, 1 bit).
  - While the owner's lock is high, preemption is suppressed and the counter is held, e.g. for an atomic read-modify-write.
  - Release on req drop is unchanged.
  - Lock from a non-owner is ignored.
- Undefined: the ports do not exist and quantum preemption always applies.

Decomposition:
- Shared package reflet_bus_pkg holds:
  - state encoding constants: ARB_IDLE = 2'd0, ARB_OWN0 = 2'd1, ARB_OWN1 = 2'd2.
  - the master index constants.
- One natural sub-module, reflet_bus_mux2: a combinational 2:1 selector for addr, write_en and data_out with a zero output when not selected. Instantiate it once for the bus side.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: reset = 1 with m0_req = 1 → grants = 0, bus_write_en = 0, bus_addr = 0. Release reset with only m0_req = 1 → m0_grant = 1 one cycle later, bus_addr = m0_addr = 8'h3C.
- Tie: both req rise together after reset → master 0 granted first. With quantum = 4 and both held, grants alternate every 4 cycles (0,0,0,0,1,1,1,1,...).
- Release handover: m0 owns and m1_req is high; drop m0_req → m1_grant high on the next edge with no IDLE cycle, and bus_write_en follows m1_write_en.
- Read gating: m1 owns, bus_data_in = 8'hA5 → m1_data_in = 8'hA5 and m0_data_in = 8'h00.
- Async reset mid-write: m0 owns with write_en = 1; pulse reset between edges → bus_write_en and m0_grant go to 0 immediately. After release, re-arbitration takes one cycle.
- REFLET_BUS_ARBITER_LOCK_EN defined: m0 owns with m0_lock = 1 and m1_req = 1 for 10 cycles → no handover. Drop m0_lock → handover after 4 further cycles, since the counter resumes from 0.
